// File: rtl/lpf_pkg.sv
// Shared constants, tap coefficients and FSM state type for the shared-MAC anti-alias FIR.
// The symmetric 72-tap set sums to 964, so a full-scale input never overflows after a 10-bit shift.
package lpf_pkg;

    localparam int TAP_W     = 8;
    localparam int TAPS      = 72;
    localparam int TAP_IDX_W = $clog2(TAPS);

    localparam logic [TAP_W-1:0] TAP_COEF [TAPS] = '{
        8'h51,
        8'h07, 8'h07, 8'h07, 8'h08, 8'h08, 8'h08, 8'h09, 8'h09, 8'h09, 8'h09, 8'h0A,
        8'h0A, 8'h0A, 8'h0B, 8'h0B, 8'h0B, 8'h0C, 8'h0C, 8'h0C, 8'h0D, 8'h0D, 8'h0D,
        8'h0E, 8'h0E, 8'h0E, 8'h0E, 8'h0E, 8'h0E, 8'h0E, 8'h0E, 8'h0E, 8'h0E, 8'h0E,
        8'h0E, 8'h0E, 8'h0E, 8'h0E, 8'h0E, 8'h0E, 8'h0E, 8'h0E, 8'h0E, 8'h0E, 8'h0E,
        8'h0E, 8'h0E, 8'h0E, 8'h0E,
        8'h0D, 8'h0D, 8'h0D, 8'h0C, 8'h0C, 8'h0C, 8'h0B, 8'h0B, 8'h0B, 8'h0A, 8'h0A,
        8'h0A, 8'h09, 8'h09, 8'h09, 8'h09, 8'h08, 8'h08, 8'h08, 8'h07, 8'h07, 8'h07,
        8'h51
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } lpf_state_e;

endpackage

// File: rtl/lpf_tap_rom.sv
// Combinational tap-index to coefficient lookup shared by the single multiplier.
module lpf_tap_rom
    import lpf_pkg::*;
(
    input  logic [TAP_IDX_W-1:0] idx,
    output logic [TAP_W-1:0]     coef
);

    // Out-of-range indices read as zero so the unused ROM space is inert.
    always_comb begin
        if (idx < TAP_IDX_W'(TAPS)) begin
            coef = TAP_COEF[idx];
        end else begin
            coef = '0;
        end
    end

endmodule

// File: rtl/lpf_mac_sched.sv
// Shares one tap lookup and one multiplier across CHANNELS audio channels of a decimating FIR.
// Optional build macro LPF_ROUND_EN: round half up at dump instead of truncating.
module lpf_mac_sched
    import lpf_pkg::*;
#(
    parameter int MSB      = 15,
    parameter int CHANNELS = 2,
    parameter int SHIFT    = 10
) (
    input  logic                         CLK,
    input  logic                         RESET,
    input  logic                         CE,
    input  logic                         ENABLE,
    input  logic [CHANNELS*(MSB+1)-1:0]  IDATA,
    output logic [CHANNELS*(MSB+1)-1:0]  ODATA,
    output logic                         OVALID,
    output logic                         BUSY,
    output logic                         OVERRUN,
    input  logic                         CLR_OVERRUN
);

    localparam int SW    = MSB + 1;
    localparam int DW    = CHANNELS * SW;
    localparam int ACC_W = SW + TAP_W + $clog2(TAPS);
    localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    localparam logic [TAP_IDX_W-1:0] TAP_LAST = TAP_IDX_W'(TAPS - 1);
    localparam logic [CH_W-1:0]      CH_LAST  = CH_W'(CHANNELS - 1);
`ifdef LPF_ROUND_EN
    localparam logic [ACC_W-1:0]     RND      = ACC_W'(1) << (SHIFT - 1);
`else
    localparam logic [ACC_W-1:0]     RND      = '0;
`endif

    lpf_state_e           state_r;
    lpf_state_e           state_nx_s;
    logic [CH_W-1:0]      ch_r;
    logic [TAP_IDX_W-1:0] tap_idx_r;
    logic [DW-1:0]        shadow_r;
    logic [ACC_W-1:0]     acc_r [CHANNELS];
    logic [DW-1:0]        out_r;
    logic                 ovalid_r;
    logic                 busy_r;
    logic                 overrun_r;

    logic [TAP_W-1:0]     coef_s;
    logic [SW-1:0]        sample_s;
    logic [ACC_W-1:0]     product_s;
    logic [ACC_W-1:0]     sum_s;
    logic [ACC_W-1:0]     dump_s;
    logic                 last_ch_s;
    logic                 frame_end_s;

    lpf_tap_rom u_rom (
        .idx  (tap_idx_r),
        .coef (coef_s)
    );

    assign last_ch_s   = (ch_r == CH_LAST);
    assign frame_end_s = (tap_idx_r == TAP_LAST);

    // Next-state logic: one capture cycle, one MAC cycle per channel, one bookkeeping cycle.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (CE) begin
                    state_nx_s = MAC;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            MAC: begin
                if (last_ch_s) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = MAC;
                end
            end
            DONE:    state_nx_s = IDLE;
            default: state_nx_s = IDLE;
        endcase
    end

    // Shared multiply-accumulate datapath for the channel currently selected.
    always_comb begin
        sample_s  = shadow_r[ch_r*SW +: SW];
        product_s = ACC_W'(coef_s) * ACC_W'(sample_s);
        sum_s     = acc_r[ch_r] + product_s;
        dump_s    = sum_s + RND;
    end

    // Scheduler state, accumulators, output registers and status flags.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r   <= IDLE;
            ch_r      <= '0;
            tap_idx_r <= '0;
            shadow_r  <= '0;
            out_r     <= '0;
            ovalid_r  <= 1'b0;
            busy_r    <= 1'b0;
            overrun_r <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                acc_r[i] <= '0;
            end
        end else begin
            state_r  <= state_nx_s;
            busy_r   <= (state_nx_s != IDLE);
            ovalid_r <= (state_r == MAC) && last_ch_s && frame_end_s;

            // A strobe that lands mid-sequence is dropped; set beats a simultaneous clear.
            if (CE && busy_r) begin
                overrun_r <= 1'b1;
            end else if (CLR_OVERRUN) begin
                overrun_r <= 1'b0;
            end

            case (state_r)
                IDLE: begin
                    if (CE) begin
                        shadow_r <= IDATA;
                        ch_r     <= '0;
                    end
                end
                MAC: begin
                    if (frame_end_s) begin
                        out_r[ch_r*SW +: SW] <= SW'(dump_s >> SHIFT);
                        acc_r[ch_r]          <= '0;
                    end else begin
                        acc_r[ch_r] <= sum_s;
                    end
                    ch_r <= ch_r + CH_W'(1);
                end
                DONE: begin
                    if (frame_end_s) begin
                        tap_idx_r <= '0;
                    end else begin
                        tap_idx_r <= tap_idx_r + TAP_IDX_W'(1);
                    end
                end
                default: begin
                    ch_r <= '0;
                end
            endcase
        end
    end

    assign ODATA   = ENABLE ? out_r : IDATA;
    assign OVALID  = ovalid_r;
    assign BUSY    = busy_r;
    assign OVERRUN = overrun_r;

endmodule

// File: tb/tb_lpf_mac_sched.sv
// Self-checking bench for lpf_mac_sched: event-scheduled reference model plus directed frames.
module tb_lpf_mac_sched;

    localparam int MSB   = 15;
    localparam int CH    = 2;
    localparam int SHIFT = 10;
    localparam int SW    = MSB + 1;
`ifdef LPF_ROUND_EN
    localparam longint RND     = 512;
    localparam int     ONE_EXP = 1;
`else
    localparam longint RND     = 0;
    localparam int     ONE_EXP = 0;
`endif

    logic              CLK = 1'b0;
    logic              RESET;
    logic              CE;
    logic              ENABLE;
    logic [CH*SW-1:0]  IDATA;
    logic [CH*SW-1:0]  ODATA;
    logic              OVALID;
    logic              BUSY;
    logic              OVERRUN;
    logic              CLR_OVERRUN;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 0;

    // reference model state
    int          coef [72];
    int          m_tap;
    longint      m_acc  [CH];
    logic [15:0] m_out  [CH];
    logic [15:0] m_pval [CH];
    int          m_pend [CH];
    int          m_busy;
    int          m_ov_cnt;
    bit          m_ovalid;
    bit          m_overrun;
    bit          busy_now;

    lpf_mac_sched #(.MSB(MSB), .CHANNELS(CH), .SHIFT(SHIFT)) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .CE          (CE),
        .ENABLE      (ENABLE),
        .IDATA       (IDATA),
        .ODATA       (ODATA),
        .OVALID      (OVALID),
        .BUSY        (BUSY),
        .OVERRUN     (OVERRUN),
        .CLR_OVERRUN (CLR_OVERRUN)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Build the symmetric coefficient set: 81 at both ends, a 7..14 ramp in between.
    task automatic build_coef();
        int cnt [8] = '{3, 3, 4, 3, 3, 3, 3, 13};
        int idx = 1;
        coef[0]  = 81;
        coef[71] = 81;
        for (int v = 0; v < 8; v++) begin
            for (int j = 0; j < cnt[v]; j++) begin
                coef[idx]      = 7 + v;
                coef[71 - idx] = 7 + v;
                idx++;
            end
        end
    endtask

    // Model step evaluated with the inputs the DUT sees at this rising edge.
    task automatic model_step();
        if (RESET) begin
            m_tap = 0; m_busy = 0; m_ov_cnt = 0; m_ovalid = 0; m_overrun = 0;
            for (int k = 0; k < CH; k++) begin
                m_acc[k] = 0; m_out[k] = '0; m_pend[k] = 0; m_pval[k] = '0;
            end
        end else begin
            busy_now = (m_busy > 0);
            if (m_busy > 0) m_busy--;
            m_ovalid = 0;
            if (m_ov_cnt > 0) begin
                m_ov_cnt--;
                if (m_ov_cnt == 0) m_ovalid = 1;
            end
            for (int k = 0; k < CH; k++) begin
                if (m_pend[k] > 0) begin
                    m_pend[k]--;
                    if (m_pend[k] == 0) m_out[k] = m_pval[k];
                end
            end
            if (CE && busy_now) m_overrun = 1;
            else if (CLR_OVERRUN) m_overrun = 0;
            if (CE && !busy_now) begin
                for (int k = 0; k < CH; k++) begin
                    m_acc[k] += longint'(coef[m_tap]) * longint'(IDATA[k*SW +: SW]);
                    if (m_tap == 71) begin
                        m_pval[k] = 16'((m_acc[k] + RND) >> SHIFT);
                        m_acc[k]  = 0;
                        m_pend[k] = k + 1;
                    end
                end
                if (m_tap == 71) m_ov_cnt = CH;
                m_busy = CH + 1;
                m_tap  = (m_tap + 1) % 72;
            end
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        model_step();
        #1;
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge CLK) begin
        if (chk_en) begin
            chk("busy", BUSY, m_busy > 0);
            chk("ovalid", OVALID, m_ovalid);
            chk("overrun", OVERRUN, m_overrun);
            chk("odata", ODATA, ENABLE ? {m_out[1], m_out[0]} : IDATA);
        end
    end

    task automatic run_ces(input int n, input logic [15:0] s0, input logic [15:0] s1);
        for (int i = 0; i < n; i++) begin
            IDATA = {s1, s0};
            CE = 1'b1;
            tick();
            CE = 1'b0;
            repeat (7) tick();
        end
    endtask

    task automatic last_ce(input logic [15:0] s0, input logic [15:0] s1,
                           input int e0, input int e1, input string name);
        bit found = 0;
        IDATA = {s1, s0};
        CE = 1'b1;
        tick();
        CE = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (!found) begin
                tick();
                @(negedge CLK);
                if (OVALID === 1'b1) found = 1;
            end
        end
        chk({name, "_ovalid_seen"}, 32'(found), 32'd1);
        chk({name, "_ch0"}, 32'(ODATA[15:0]), 32'(e0));
        chk({name, "_ch1"}, 32'(ODATA[31:16]), 32'(e1));
        repeat (4) tick();
    endtask

    task automatic frame(input logic [15:0] s0, input logic [15:0] s1,
                         input int e0, input int e1, input string name);
        run_ces(71, s0, s1);
        last_ce(s0, s1, e0, e1, name);
    endtask

    initial begin
        build_coef();
        RESET = 1'b1; CE = 1'b0; ENABLE = 1'b1; IDATA = '0; CLR_OVERRUN = 1'b0;
        repeat (3) tick();
        chk_en = 1;
        @(negedge CLK);
        chk("rst_busy", BUSY, 1'b0);
        chk("rst_ovalid", OVALID, 1'b0);
        chk("rst_overrun", OVERRUN, 1'b0);
        chk("rst_odata", ODATA, 32'h0);
        RESET = 1'b0;
        tick();

        frame(16'd1024, 16'd0, 964, 0, "full_scale");
        frame(16'd1023, 16'd0, 963, 0, "f1023");
        frame(16'd1, 16'd0, ONE_EXP, 0, "f1");

        // back-to-back strobes: second one dropped
        IDATA = {16'd0, 16'd1024};
        CE = 1'b1;
        tick();
        tick();
        CE = 1'b0;
        @(negedge CLK);
        chk("overrun_set", OVERRUN, 1'b1);
        repeat (6) tick();
        run_ces(70, 16'd1024, 16'd0);
        last_ce(16'd1024, 16'd0, 964, 0, "after_overrun");

        CLR_OVERRUN = 1'b1;
        tick();
        CLR_OVERRUN = 1'b0;
        @(negedge CLK);
        chk("overrun_clr", OVERRUN, 1'b0);

        CE = 1'b1;
        tick();
        CLR_OVERRUN = 1'b1;
        tick();
        CE = 1'b0;
        CLR_OVERRUN = 1'b0;
        @(negedge CLK);
        chk("overrun_set_wins", OVERRUN, 1'b1);
        repeat (6) tick();

        // reset in the middle of the tap-40 pass
        run_ces(39, 16'd1024, 16'd0);
        CE = 1'b1;
        tick();
        CE = 1'b0;
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        @(negedge CLK);
        chk("midrst_busy", BUSY, 1'b0);
        chk("midrst_ovalid", OVALID, 1'b0);
        chk("midrst_overrun", OVERRUN, 1'b0);
        chk("midrst_odata", ODATA, 32'h0);
        tick();
        frame(16'd1024, 16'd0, 964, 0, "after_reset");

        // bypass, then re-enable shows the frame computed while bypassed
        ENABLE = 1'b0;
        IDATA = {16'h0000, 16'h1234};
        #1;
        chk("bypass", 32'(ODATA[15:0]), 32'h1234);
        run_ces(72, 16'd1024, 16'd0);
        ENABLE = 1'b1;
        #1;
        chk("reenable_ch0", 32'(ODATA[15:0]), 32'd964);
        chk("reenable_ch1", 32'(ODATA[31:16]), 32'd0);
        frame(16'd1023, 16'd0, 963, 0, "post_reenable");

        // randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            RESET       = ($urandom_range(0, 1999) == 0);
            CE          = ($urandom_range(0, 5) == 0);
            CLR_OVERRUN = ($urandom_range(0, 19) == 0);
            ENABLE      = ($urandom_range(0, 9) != 0);
            IDATA       = $urandom;
            tick();
        end
        RESET = 1'b0; CE = 1'b0; CLR_OVERRUN = 1'b0;
        repeat (4) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
